regfile_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the multicycle and pipelined MIPS cores, successor to the fixed 2-read/1-write 32×32 file. Width, depth, read-port count and write-port count are generics. A built-in clear sequencer zeroes every entry after reset or on request, so no simulation-only initialisation is needed. An optional write-to-read bypass is available for pipelined datapaths. Entry 0 is hardwired to zero, as MIPS `$zero` requires.

---
 rtl/regfile_mp_if.sv | 21 ++
 rtl/regfile_mp.sv | 116 +++++++++++
 tb/tb_regfile_mp.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle for the multi-port register file.
//   master : drives clr, we, wa, wd, ra; observes rd, busy
//   slave  : the register file itself
// Multi-port fields are packed, with port p at [p*W +: W].
interface regfile_mp_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
);
  logic                         clr;
  logic [NUM_WR-1:0]            we;
  logic [NUM_WR*ADDR_SIZE-1:0]  wa;
  logic [NUM_WR*DATA_WIDTH-1:0] wd;
  logic [NUM_RD*ADDR_SIZE-1:0]  ra;
  logic [NUM_RD*DATA_WIDTH-1:0] rd;
  logic                         busy;

  modport master (output clr, we, wa, wd, ra, input rd, busy);
  modport slave  (input clr, we, wa, wd, ra, output rd, busy);
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with a built-in clear
// sequencer. Entry 0 always reads zero. Reads are combinational.
//
// Ports:
//   clk_i   clock, all state updates on the rising edge
//   rst_i   synchronous active-high reset (restarts the clear sequence)
//   bus_if  regfile_mp_if.slave: clr, we, wa, wd, ra in; rd, busy out
//
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write
// data to matching read ports (highest-numbered write port wins).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zeroing rf[cnt] each edge; writes/clr ignored; busy=1
// ST_RUN   | normal operation; clr restarts the clear sequence
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_SIZE  = 5,
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  regfile_mp_if.slave  bus_if
);

  localparam int DEPTH = 2**ADDR_SIZE;
  localparam logic [ADDR_SIZE-1:0] CNT_LAST = '1;

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [ADDR_SIZE-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  rf_q [DEPTH];
  logic [DATA_WIDTH-1:0]  rf_d [DEPTH];
  logic                   busy;
  logic                   run_wr;

  assign busy        = (state_q == ST_CLEAR);
  assign bus_if.busy = busy;
  // Writes (and the bypass) are live only in RUN with no clear request.
  assign run_wr      = (state_q == ST_RUN) && !bus_if.clr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        if (bus_if.clr) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Ports are applied in ascending order so the highest-numbered port wins.
  always_comb begin
    rf_d = rf_q;
    if (busy) begin
      rf_d[cnt_q] = '0;
    end else if (run_wr) begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (bus_if.we[p] && (bus_if.wa[p*ADDR_SIZE +: ADDR_SIZE] != '0)) begin
          rf_d[bus_if.wa[p*ADDR_SIZE +: ADDR_SIZE]] = bus_if.wd[p*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Reset only needs entry 0 zeroed immediately; the rest are hidden by
  // busy until the sequencer has cleared them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_CLEAR;
      cnt_q    <= '0;
      rf_q[0]  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_q    <= rf_d;
    end
  end

  always_comb begin
    bus_if.rd = '0;
    for (int q = 0; q < NUM_RD; q++) begin
      if (!busy && (bus_if.ra[q*ADDR_SIZE +: ADDR_SIZE] != '0)) begin
        bus_if.rd[q*DATA_WIDTH +: DATA_WIDTH] = rf_q[bus_if.ra[q*ADDR_SIZE +: ADDR_SIZE]];
`ifdef REGFILE_BYPASS_EN
        if (run_wr) begin
          for (int p = 0; p < NUM_WR; p++) begin
            if (bus_if.we[p] &&
                (bus_if.wa[p*ADDR_SIZE +: ADDR_SIZE] == bus_if.ra[q*ADDR_SIZE +: ADDR_SIZE])) begin
              bus_if.rd[q*DATA_WIDTH +: DATA_WIDTH] = bus_if.wd[p*DATA_WIDTH +: DATA_WIDTH];
            end
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;

  regfile_mp_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_mp #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .bus_if (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: kind 0 = rd port 0, 1 = rd port 1, 2 = busy
  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } sb_t;
  sb_t sb[$];

  // Reference model: register contents plus remaining busy cycles.
  logic [31:0] mem [32];
  int          clr_left;

  task automatic push(input int kind, input logic [31:0] exp, input string name);
    sb_t e;
    e.cyc = cyc; e.kind = kind; e.exp = exp; e.name = name;
    sb.push_back(e);
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    logic [31:0] r;
    if (clr_left > 0 || ra == 5'd0) return 32'h0;
    r = mem[ra];
`ifdef REGFILE_BYPASS_EN
    if (!bus.clr)
      for (int p = 0; p < NW; p++)
        if (bus.we[p] && bus.wa[p*AW +: AW] == ra) r = bus.wd[p*DW +: DW];
`endif
    return r;
  endfunction

  task automatic model_edge();
    if (rst) begin
      clr_left = 32;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else if (clr_left > 0) begin
      clr_left--;
    end else if (bus.clr) begin
      clr_left = 32;
      for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    end else begin
      for (int p = 0; p < NW; p++)
        if (bus.we[p] && bus.wa[p*AW +: AW] != 5'd0)
          mem[bus.wa[p*AW +: AW]] = bus.wd[p*DW +: DW];
    end
  endtask

  // One clock cycle: queue model expectations for current inputs, take the edge.
  task automatic step(input bit chk);
    if (chk) begin
      push(0, exp_rd(bus.ra[4:0]), "model_rd0");
      push(1, exp_rd(bus.ra[9:5]), "model_rd1");
      push(2, {31'b0, clr_left > 0}, "model_busy");
    end
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    bus.clr = 1'b0; bus.we = '0; bus.wa = '0; bus.wd = '0;
  endtask

  task automatic rand_wr();
    bus.we = 2'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      bus.wa[4:0] = 5'($urandom_range(0, 3));
      bus.wa[9:5] = 5'($urandom_range(0, 3));
    end else begin
      bus.wa = 10'($urandom);
    end
    bus.wd = {$urandom, $urandom};
  endtask

  task automatic rand_rd();
    bus.ra[4:0] = ($urandom_range(0, 3) == 0) ? bus.wa[4:0] : 5'($urandom);
    bus.ra[9:5] = ($urandom_range(0, 3) == 0) ? bus.wa[9:5] : 5'($urandom);
  endtask

  // Monitor: compare everything due in the current cycle, away from the edge.
  always @(negedge clk) begin
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      sb_t e;
      e = sb.pop_front();
      case (e.kind)
        0:       act = bus.rd[31:0];
        1:       act = bus.rd[63:32];
        default: act = {31'b0, bus.busy};
      endcase
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, e.cyc, act, e.exp);
      end
    end
  end

  initial begin
    checks = 0; errors = 0; clr_left = 32;
    for (int i = 0; i < 32; i++) mem[i] = 32'h0;
    rst = 1'b1; idle(); bus.ra = '0;
    step(0);
    rst = 1'b0;
    for (int i = 0; i < 33; i++) step(1);

    // Preload, then reset and watch the clear sequence.
    for (int i = 0; i < 40; i++) begin rand_wr(); rand_rd(); step(1); end
    idle(); rst = 1'b1;
    step(1);
    rst = 1'b0;
    push(2, 32'h1, "rst_busy_first");
    push(0, 32'h0, "rst_rd0_first");
    for (int i = 0; i < 32; i++) begin
      rand_wr(); rand_rd();
      push(2, 32'h1, "rst_busy");
      push(0, 32'h0, "rst_rd0_zero");
      push(1, 32'h0, "rst_rd1_zero");
      step(1);
    end
    idle();
    for (int a = 1; a < 32; a++) begin
      bus.ra = {5'(a), 5'(a)};
      push(2, 32'h0, "rst_done");
      push(0, 32'h0, "rst_clear_rd0");
      step(1);
    end

    // Basic write/read on both read ports.
    bus.we = 2'b01; bus.wa = {5'd0, 5'd5}; bus.wd = {32'h0, 32'hDEADBEEF};
    step(1);
    idle(); bus.ra = {5'd5, 5'd5};
    push(0, 32'hDEADBEEF, "basic_rd0");
    push(1, 32'hDEADBEEF, "basic_rd1");
    step(1);

    // Writes to $zero are dropped.
    bus.we = 2'b01; bus.wa = {5'd0, 5'd0}; bus.wd = {32'h0, 32'h12345678};
    step(1);
    idle(); bus.ra = {5'd0, 5'd0};
    push(0, 32'h0, "zero_rd0");
    step(1);

    // Same-address conflict: highest port wins.
    bus.we = 2'b11; bus.wa = {5'd7, 5'd7}; bus.wd = {32'h2222, 32'h1111};
    step(1);
    idle(); bus.ra = {5'd0, 5'd7};
    push(0, 32'h2222, "conflict_rd0");
    step(1);

    // Same-cycle read of a write target.
    bus.we = 2'b01; bus.wa = {5'd0, 5'd9}; bus.wd = {32'h0, 32'hA5A5A5A5};
    bus.ra = {5'd0, 5'd9};
`ifdef REGFILE_BYPASS_EN
    push(0, 32'hA5A5A5A5, "bypass_same");
`else
    push(0, 32'h0, "bypass_same");
`endif
    step(1);
    idle();
    push(0, 32'hA5A5A5A5, "bypass_next");
    step(1);

    // clr with a simultaneous write; writes while busy are lost.
    bus.clr = 1'b1; bus.we = 2'b01; bus.wa = {5'd0, 5'd3}; bus.wd = {32'h0, 32'hFF};
    push(2, 32'h0, "clr_busy_same");
    step(1);
    idle();
    for (int i = 0; i < 32; i++) begin
      rand_wr(); rand_rd();
      push(2, 32'h1, "clr_busy");
      step(1);
    end
    idle(); bus.ra = {5'd0, 5'd3};
    push(2, 32'h0, "clr_done");
    push(0, 32'h0, "clr_rd3");
    step(1);
    for (int a = 1; a < 32; a++) begin
      bus.ra = {5'(a), 5'(a)};
      push(0, 32'h0, "busy_we_lost0");
      push(1, 32'h0, "busy_we_lost1");
      step(1);
    end

    // Random traffic with occasional clr and reset.
    for (int i = 0; i < 600; i++) begin
      rand_wr(); rand_rd();
      bus.clr = ($urandom_range(0, 59) == 0);
      rst = ($urandom_range(0, 149) == 0);
      step(1);
    end
    rst = 1'b0; idle();

    @(negedge clk); @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain left=%0d exp=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
